// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable controller.
// Widths, state encoding and the board/simulation prescale constants.
package cpu_clk_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned BURST_W_DEF = 8;
    localparam int unsigned TICK_W_DEF  = 16;

    // Terminal value for a 1 Hz tick from a 50 MHz board clock, and a fast value for simulation
    localparam logic [CNT_W_DEF-1:0] DIV_BOARD = CNT_W_DEF'(49999999);
    localparam logic [CNT_W_DEF-1:0] DIV_SIM   = CNT_W_DEF'(1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_e;

    // States in which the prescale divider counts
    function automatic logic divider_active(input state_e s);
        return (s == ST_RUN) || (s == ST_BURST);
    endfunction

endpackage

// File: rtl/cpu_clk_divider.sv
// Programmable prescale counter for the CPU clock-enable controller.
// Counts while enabled, clears on terminal or when disabled; terminal is cnt >= div.
module cpu_clk_divider
    import cpu_clk_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] div_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal compare is >= so a lowered div fires immediately instead of waiting for wrap
    assign term_o = (cnt_q >= div_i);
    assign cnt_o  = cnt_q;

    // Next count: clear when idle or on the terminal cycle, otherwise advance
    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (term_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/step/burst controller producing the CPU clock-enable pulse.
// Optional burst mode is compiled in when CPU_CLK_BURST_EN is defined.
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF,
    parameter int unsigned TICK_W  = TICK_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   div,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic               burst_req,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cpu_en,
    output logic [1:0]         state,
    output logic [TICK_W-1:0]  tick_cnt
);

    state_e              state_q;
    state_e              state_d;
    logic [TICK_W-1:0]   tick_q;
    logic [TICK_W-1:0]   tick_d;
    logic                div_en_c;
    logic                term_c;
    logic [CNT_W-1:0]    unused_cnt;

`ifdef CPU_CLK_BURST_EN
    logic [BURST_W-1:0]  remaining_q;
    logic [BURST_W-1:0]  remaining_d;
`else
    logic                unused_burst;
    assign unused_burst = ^{burst_req, burst_len};
`endif

    // Divider runs only in the free-running and burst states
    assign div_en_c = divider_active(state_q);

    cpu_clk_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .enable_i (div_en_c),
        .div_i    (div),
        .cnt_o    (unused_cnt),
        .term_o   (term_c)
    );

    // Clock enable is a pure decode of registers so reset removes it asynchronously
    assign cpu_en   = (div_en_c && term_c) || (state_q == ST_STEP);
    assign state    = state_q;
    assign tick_cnt = tick_q;

    // Next state and burst countdown; halt_req > run_req > burst_req > step_req
    always_comb begin
        state_d = state_q;
`ifdef CPU_CLK_BURST_EN
        remaining_d = remaining_q;
`endif
        case (state_q)
            ST_HALT: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (run_req) begin
                    state_d = ST_RUN;
`ifdef CPU_CLK_BURST_EN
                end else if (burst_req && (burst_len != '0)) begin
                    state_d     = ST_BURST;
                    remaining_d = burst_len;
`endif
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
`ifdef CPU_CLK_BURST_EN
            ST_BURST: begin
                if (halt_req) begin
                    state_d     = ST_HALT;
                    remaining_d = '0;
                end else if (cpu_en) begin
                    remaining_d = remaining_q - BURST_W'(1);
                    if (remaining_q == BURST_W'(1)) begin
                        state_d = ST_HALT;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Tick counter advances on every enabled cycle and wraps
    always_comb begin
        tick_d = tick_q;
        if (cpu_en) begin
            tick_d = tick_q + TICK_W'(1);
        end
    end

    // State, tick and burst registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HALT;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

`ifdef CPU_CLK_BURST_EN
    // Burst remaining-pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares on every cpu_en.
module tb_cpu_clock_ctrl;
    import cpu_clk_pkg::*;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned TICK_W  = 16;

    logic               clk;
    logic               reset;
    logic [CNT_W-1:0]   div;
    logic               run_req;
    logic               halt_req;
    logic               step_req;
    logic               burst_req;
    logic [BURST_W-1:0] burst_len;
    logic               cpu_en;
    logic [1:0]         state;
    logic [TICK_W-1:0]  tick_cnt;

    typedef struct {
        int cyc;
        int tick;
        int st;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_ticks = 0;
    int   e0;

    cpu_clock_ctrl #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W),
        .TICK_W  (TICK_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .div       (div),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .burst_req (burst_req),
        .burst_len (burst_len),
        .cpu_en    (cpu_en),
        .state     (state),
        .tick_cnt  (tick_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index: value seen during the cycle that follows each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int c, input int st);
        exp_t e;
        e.cyc  = c;
        e.tick = exp_ticks;
        e.st   = st;
        sb_q.push_back(e);
        exp_ticks++;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every cpu_en must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_en) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got cpu_en=1 at cyc %0d, required no pulse", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("pulse_cyc", cyc, mon_e.cyc);
                    chk("pulse_tick", tick_cnt, mon_e.tick);
                    chk("pulse_state", state, mon_e.st);
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_pulse: got none by cyc %0d, required pulse at cyc %0d", cyc, sb_q[0].cyc);
                mon_e = sb_q.pop_front();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        div       = CNT_W'(3);
        run_req   = 1'b0;
        halt_req  = 1'b0;
        step_req  = 1'b0;
        burst_req = 1'b0;
        burst_len = '0;
        #3;
        chk("reset_state", state, 0);
        chk("reset_tick", tick_cnt, 0);
        chk("reset_cpu_en", cpu_en, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Free run div=3: pulses in cycles 4, 8, 12; halt on the 12th-cycle pulse
        run_req = 1'b1;
        e0 = cyc + 1;
        push(e0 + 3, ST_RUN);
        push(e0 + 7, ST_RUN);
        push(e0 + 11, ST_RUN);
        @(negedge clk);
        run_req = 1'b0;
        chk("run_state", state, ST_RUN);
        wait_cyc(e0 + 11);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk("run_halt_state", state, ST_HALT);
        chk("run_tick3", tick_cnt, 3);
        repeat (6) @(negedge clk);

        // Single step, second step while in STEP ignored
        step_req = 1'b1;
        e0 = cyc + 1;
        push(e0, ST_STEP);
        @(negedge clk);
        chk("step_state", state, ST_STEP);
        @(negedge clk);
        step_req = 1'b0;
        chk("step_back_halt", state, ST_HALT);
        repeat (4) @(negedge clk);
        chk("step_tick", tick_cnt, exp_ticks);

        // Burst of 5 at div=2
        div       = CNT_W'(2);
        burst_req = 1'b1;
        burst_len = BURST_W'(5);
        e0 = cyc + 1;
`ifdef CPU_CLK_BURST_EN
        for (int i = 0; i < 5; i++) push(e0 + 2 + 3 * i, ST_BURST);
`endif
        @(negedge clk);
        burst_req = 1'b0;
        burst_len = '0;
`ifdef CPU_CLK_BURST_EN
        chk("burst_state", state, ST_BURST);
        wait_cyc(e0 + 15);
        chk("burst_done_state", state, ST_HALT);
`else
        chk("burst_off_state", state, ST_HALT);
        repeat (16) @(negedge clk);
`endif
        chk("burst_tick", tick_cnt, exp_ticks);

        // Zero-length burst ignored
        burst_req = 1'b1;
        burst_len = '0;
        @(negedge clk);
        burst_req = 1'b0;
        chk("burst0_state", state, ST_HALT);
        repeat (4) @(negedge clk);

        // div lowered from 10 to 4 while cnt is 7
        div     = CNT_W'(10);
        run_req = 1'b1;
        e0 = cyc + 1;
        push(e0 + 8, ST_RUN);
        push(e0 + 13, ST_RUN);
        push(e0 + 18, ST_RUN);
        @(negedge clk);
        run_req = 1'b0;
        wait_cyc(e0 + 7);
        chk("div_cnt7", dut.u_div.cnt_q, 7);
        @(posedge clk);
        #1;
        div = CNT_W'(4);
        wait_cyc(e0 + 18);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk("div_halt_state", state, ST_HALT);
        repeat (6) @(negedge clk);

        // halt_req and run_req together from HALT stay in HALT
        div      = '0;
        halt_req = 1'b1;
        run_req  = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        run_req  = 1'b0;
        chk("halt_run_same", state, ST_HALT);
        repeat (3) @(negedge clk);

        // Burst aborted with 3 pulses remaining
        div       = CNT_W'(2);
        burst_req = 1'b1;
        burst_len = BURST_W'(5);
        e0 = cyc + 1;
`ifdef CPU_CLK_BURST_EN
        push(e0 + 2, ST_BURST);
        push(e0 + 5, ST_BURST);
`endif
        @(negedge clk);
        burst_req = 1'b0;
        burst_len = '0;
        wait_cyc(e0 + 6);
`ifdef CPU_CLK_BURST_EN
        chk("abort_rem3", dut.remaining_q, 3);
`endif
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk("abort_state", state, ST_HALT);
`ifdef CPU_CLK_BURST_EN
        chk("abort_rem0", dut.remaining_q, 0);
`endif
        repeat (8) @(negedge clk);
        chk("abort_tick", tick_cnt, exp_ticks);

        // Async reset mid-RUN with div=0 while cpu_en is high
        div     = '0;
        run_req = 1'b1;
        e0 = cyc + 1;
        push(e0, ST_RUN);
        push(e0 + 1, ST_RUN);
        push(e0 + 2, ST_RUN);
        @(negedge clk);
        run_req = 1'b0;
        wait_cyc(e0 + 2);
        @(posedge clk);
        #1;
        chk("prereset_cpu_en", cpu_en, 1);
        #1;
        reset = 1'b1;
        exp_ticks = 0;
        #1;
        chk("areset_cpu_en", cpu_en, 0);
        chk("areset_state", state, ST_HALT);
        chk("areset_cnt", dut.u_div.cnt_q, 0);
        chk("areset_tick", tick_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_reset_state", state, ST_HALT);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run/halt/step controller for the 4-bit CPU's clock enable. It owns a programmable prescale divider and a small mode FSM. It emits a one-cycle `cpu_en` pulse that the CPU core uses as a clock enable, either free-running at the divided rate, one pulse per single-step request, or a counted burst. It sits between the board clock/reset and the CPU core, driven by the debug or front-panel logic.

## Interface
Parameters:
- `CNT_W`, 32, width of the divider and of `div`
- `BURST_W`, 8, width of `burst_len` and the burst remaining counter
- `TICK_W`, 16, width of `tick_cnt`

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `div`  in  CNT_W  prescale terminal value; tick period is div+1 cycles
- `run_req`  in  1  pulse; HALT -> RUN
- `halt_req`  in  1  pulse; any state -> HALT
- `step_req`  in  1  pulse; in HALT, issue exactly one tick
- `burst_req`  in  1  pulse; in HALT, issue `burst_len` ticks, then halt
- `burst_len`  in  BURST_W  burst tick count, sampled with `burst_req`
- `cpu_en`  out  1  one-cycle clock-enable pulse to the CPU
- `state`  out  2  0=HALT, 1=RUN, 2=STEP, 3=BURST
- `tick_cnt`  out  TICK_W  count of asserted `cpu_en` cycles, wraps

## Operation
- Registers: `state`, divider `cnt` (CNT_W), `remaining` (BURST_W), `tick_cnt`.
- Reset values: state=HALT, cnt=0, remaining=0, tick_cnt=0, cpu_en=0.
- `cpu_en` is a combinational decode of registers only. It is 1 when (state∈{RUN,BURST} and cnt>=div) or state=STEP.
- Divider, in RUN/BURST:
  - cnt<=0 on any cycle with cpu_en=1; otherwise cnt<=cnt+1.
  - The compare is `>=`, so lowering `div` below the current `cnt` produces a tick on the next cycle; there is no wait for wrap-around.
  - In HALT/STEP: cnt<=0.
- Request priority, evaluated each edge: halt_req > run_req > burst_req > step_req.
- Transitions:
  - HALT: run_req -> RUN; burst_req with burst_len≠0 -> BURST and remaining<=burst_len; step_req -> STEP; burst_len=0 is ignored.
  - RUN: halt_req -> HALT; other requests are ignored.
  - STEP: unconditionally -> HALT after one cycle. halt_req in this cycle still goes to HALT, and the step tick is not suppressed.
  - BURST: halt_req -> HALT (abort; remaining<=0). On a cycle with cpu_en=1: remaining<=remaining-1; if remaining==1 -> HALT.
- `tick_cnt` increments on every edge where cpu_en=1 and wraps modulo 2^TICK_W. Only reset clears it.
- Reset asserted mid-operation clears all state immediately. `cpu_en` drops asynchronously, with no trailing tick.

## Timing
- Requests are sampled on the rising edge of `clk`; the new state is visible the following cycle.
- RUN entered at edge E0: first cpu_en occurs in the (div+1)-th cycle after E0, then every div+1 cycles. With div=0, cpu_en stays high continuously.
- STEP: cpu_en is high for exactly the one cycle after the sampling edge, latency 1.
- BURST of N: exactly N pulses spaced div+1 cycles apart. state=HALT in the cycle after the N-th pulse.
- A halt_req sampled in a cycle that already has cpu_en=1 does not retract that pulse; no further pulses follow.

## Configuration
- `CPU_CLK_BURST_EN`
- Defined: BURST state, the `remaining` register and `burst_req` handling are compiled in.
- Undefined:
  - `burst_req`/`burst_len` ports remain but are ignored.
  - BURST is unreachable and `remaining` is removed.
  - state never reads 3.

## Structure
- Shared package `cpu_clk_pkg` holds:
  - state encodings (`ST_HALT`, `ST_RUN`, `ST_STEP`, `ST_BURST`)
  - default widths (CNT_W/BURST_W/TICK_W)
  - the default divide constant (board rate 49999999, simulation rate 1)
- One sub-module, `cpu_clk_divider`:
  - inputs: enable, div
  - outputs: cnt, terminal flag (cnt>=div)
  - async reset and clear-on-disable
- The FSM, burst counter and tick counter stay in `cpu_clock_ctrl`.

## Test plan
- Reset, then div=3, run_req pulse -> cpu_en high in cycles 4, 8, 12 after the request edge; tick_cnt=3 after cycle 12.
- HALT, step_req pulse -> exactly one cpu_en cycle at latency 1, state returns to 0; a second step_req while in STEP is ignored.
- div=2, burst_req with burst_len=5 -> 5 pulses spaced 3 cycles apart, then state=0. burst_len=0 -> no pulses, state stays 0. With the macro undefined -> no pulses.
- RUN with div=10 and cnt=7, change div to 4 -> cpu_en on the next cycle, then period 5.
- halt_req and run_req on the same edge from HALT -> stays HALT. halt_req during BURST with 3 pulses remaining -> no further pulses, remaining=0.
- Async reset asserted mid-RUN while cpu_en=1 -> cpu_en, state, cnt and tick_cnt all read 0 before the next clock edge.
